// File: rtl/matrix_inverse_gj.sv
// N x N fixed-point matrix inverter: Gauss-Jordan elimination with first-nonzero
// partial pivoting, a serial restoring reciprocal divider and one element update per cycle.
module matrix_inverse_gj #(
  parameter int N    = 5,
  parameter int W    = 32,
  parameter int FRAC = 16,
  parameter int AW   = $clog2(N * N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          singular,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  data_out
);

  localparam int RW = $clog2(N);
  localparam int CW = $clog2(2 * W);
  localparam int NN = N * N;
  localparam logic [RW-1:0] LAST = RW'(N - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(2 * W - 1);
  localparam logic [2*W-1:0] ONE_WIDE = (2 * W)'(1) << FRAC;
  localparam logic signed [W-1:0] ONE = ONE_WIDE[W-1:0];
  localparam logic [2*W-1:0] DVD_INIT = (2 * W)'(1) << (2 * FRAC);
  localparam logic signed [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};
  localparam logic [2*W-1:0] MAXQ = {{(W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic [2*W-1:0] MINQ = {{W{1'b0}}, 1'b1, {(W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_SEARCH, S_SWAP, S_DIV, S_NORM, S_ELIM, S_FIN
  } state_t;

  state_t state, state_n;

  logic signed [W-1:0] a_m [NN];
  logic signed [W-1:0] i_m [NN];
  logic [RW-1:0]       k, r, p, j;
  logic                elim_lat, sing_pend, piv_neg;
  logic signed [W-1:0] f;
  logic [CW-1:0]       div_cnt;
  logic [2*W-1:0]      dvd, q;
  logic [W-1:0]        rem, den;

  logic signed [W-1:0] a_rk, a_pk, recip;
  logic [W:0]          rem_sh, rem_sub;
  logic [RW:0]         r_nxt;
  logic                found, last_row;

  function automatic logic [AW-1:0] ix(input logic [RW-1:0] row, input logic [RW-1:0] col);
    return AW'(int'(row) * N + int'(col));
  endfunction

  function automatic logic signed [W-1:0] sat_w(input logic signed [2*W:0] x);
    if (x[2*W:W-1] == {(W+2){x[2*W]}}) return x[W-1:0];
    return x[2*W] ? MINV : MAXV;
  endfunction

  // Full 2W-bit product, arithmetic (floor) shift, widened by one bit for subtraction.
  function automatic logic signed [2*W:0] mul_sh(input logic signed [W-1:0] x,
                                                 input logic signed [W-1:0] y);
    logic signed [2*W-1:0] xe, ye, pr;
    xe = {{W{x[W-1]}}, x};
    ye = {{W{y[W-1]}}, y};
    pr = xe * ye;
    pr = pr >>> FRAC;
    return {pr[2*W-1], pr};
  endfunction

  function automatic logic signed [W-1:0] elim_upd(input logic signed [W-1:0] x,
                                                   input logic signed [W-1:0] fv,
                                                   input logic signed [W-1:0] y);
    logic signed [2*W:0] xe;
    xe = {{(W+1){x[W-1]}}, x};
    return sat_w(xe - mul_sh(fv, y));
  endfunction

  function automatic logic signed [W-1:0] recip_sat(input logic [2*W-1:0] qv, input logic neg);
    if (!neg) return (qv > MAXQ) ? MAXV : qv[W-1:0];
    return (qv > MINQ) ? MINV : -qv[W-1:0];
  endfunction

  always_comb begin
    a_rk     = a_m[ix(r, k)];
    a_pk     = a_m[ix(p, k)];
    found    = (a_rk != '0);
    recip    = recip_sat(q, piv_neg);
    rem_sh   = {rem, dvd[2*W-1]};
    rem_sub  = rem_sh - {1'b0, den};
    r_nxt    = {1'b0, r} + (RW+1)'(1);
    if (r_nxt == {1'b0, k}) r_nxt = r_nxt + (RW+1)'(1);
    last_row = (r_nxt > (RW+1)'(N - 1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    busy    = 1'b1;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_n = S_SEARCH;
      end
      S_SEARCH: begin
        if (found)          state_n = S_SWAP;
        else if (r == LAST) state_n = S_FIN;
      end
      S_SWAP: state_n = S_DIV;
      S_DIV:  if (div_cnt == DIV_LAST) state_n = S_NORM;
      S_NORM: if (j == LAST) state_n = S_ELIM;
      S_ELIM: if (!elim_lat && j == LAST && last_row) state_n = (k == LAST) ? S_FIN : S_SEARCH;
      S_FIN:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NN; i++) begin
        a_m[i] <= '0;
        i_m[i] <= '0;
      end
      k         <= '0;
      r         <= '0;
      p         <= '0;
      j         <= '0;
      elim_lat  <= 1'b0;
      f         <= '0;
      div_cnt   <= '0;
      dvd       <= '0;
      q         <= '0;
      rem       <= '0;
      den       <= '0;
      piv_neg   <= 1'b0;
      sing_pend <= 1'b0;
      singular  <= 1'b0;
      done      <= 1'b0;
      data_out  <= '0;
    end else begin
      done     <= 1'b0;
      data_out <= (int'(rd_addr) < NN) ? i_m[rd_addr] : '0;
      case (state)
        S_IDLE: begin
          if (wr_en && int'(wr_addr) < NN) a_m[wr_addr] <= wr_data;
          if (start) begin
            for (int i = 0; i < NN; i++) i_m[i] <= (i % (N + 1) == 0) ? ONE : '0;
            singular  <= 1'b0;
            sing_pend <= 1'b0;
            k         <= '0;
            r         <= '0;
          end
        end
        S_SEARCH: begin
          if (found)          p <= r;
          else if (r == LAST) sing_pend <= 1'b1;
          else                r <= r + 1'b1;
        end
        S_SWAP: begin
          for (int c = 0; c < N; c++) begin
            a_m[ix(k, RW'(c))] <= a_m[ix(p, RW'(c))];
            a_m[ix(p, RW'(c))] <= a_m[ix(k, RW'(c))];
            i_m[ix(k, RW'(c))] <= i_m[ix(p, RW'(c))];
            i_m[ix(p, RW'(c))] <= i_m[ix(k, RW'(c))];
          end
          den     <= a_pk[W-1] ? -a_pk : a_pk;
          piv_neg <= a_pk[W-1];
          dvd     <= DVD_INIT;
          q       <= '0;
          rem     <= '0;
          div_cnt <= '0;
          j       <= '0;
        end
        S_DIV: begin
          if (!rem_sub[W]) begin
            rem <= rem_sub[W-1:0];
            q   <= {q[2*W-2:0], 1'b1};
          end else begin
            rem <= rem_sh[W-1:0];
            q   <= {q[2*W-2:0], 1'b0};
          end
          dvd     <= dvd << 1;
          div_cnt <= div_cnt + 1'b1;
        end
        S_NORM: begin
          a_m[ix(k, j)] <= sat_w(mul_sh(a_m[ix(k, j)], recip));
          i_m[ix(k, j)] <= sat_w(mul_sh(i_m[ix(k, j)], recip));
          if (j == LAST) begin
            j        <= '0;
            r        <= (k == '0) ? RW'(1) : '0;
            elim_lat <= 1'b1;
          end else begin
            j <= j + 1'b1;
          end
        end
        S_ELIM: begin
          if (elim_lat) begin
            f        <= a_rk;
            elim_lat <= 1'b0;
            j        <= '0;
          end else begin
            a_m[ix(r, j)] <= elim_upd(a_m[ix(r, j)], f, a_m[ix(k, j)]);
            i_m[ix(r, j)] <= elim_upd(i_m[ix(r, j)], f, i_m[ix(k, j)]);
            if (j == LAST) begin
              j        <= '0;
              elim_lat <= 1'b1;
              if (last_row) begin
                if (k != LAST) begin
                  k <= k + 1'b1;
                  r <= k + 1'b1;
                end
              end else begin
                r <= r_nxt[RW-1:0];
              end
            end else begin
              j <= j + 1'b1;
            end
          end
        end
        S_FIN: begin
          done     <= 1'b1;
          singular <= sing_pend;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/matrix_inverse_gj.md
# matrix_inverse_gj

Parametrised N×N fixed-point matrix inverter using Gauss-Jordan elimination with first-nonzero partial pivoting. It is the successor to the fixed 5×5 inverse engine. It adds:
- a write port for loading the matrix,
- a start/busy/done handshake,
- singular-matrix detection,
- generic size and fixed-point format.

The inverse is read back through an addressed, registered read port. A host controller or test harness loads the matrix, starts the block, then sweeps the addresses to read the result.

## Interface
- N, 5: matrix dimension, 2..8.
- W, 32: element width, signed two's complement.
- FRAC, 16: fractional bits, Q(W−FRAC).FRAC; requires 2·FRAC < 2·W.
- AW, clog2(N·N): address width; address = row·N + col.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  1  write wr_data into A[wr_addr]; honoured only when idle.
- wr_addr  in  AW  write element index.
- wr_data  in  W  element value.
- start  in  1  begin inversion; honoured only when idle.
- busy  out  1  high while computing.
- done  out  1  one-cycle completion pulse.
- singular  out  1  level; set with done if no usable pivot was found; cleared on the next accepted start.
- rd_addr  in  AW  read element index into the inverse array I.
- data_out  out  W  registered I[rd_addr].

## Operation
- Storage:
  - A: N×N working matrix, loaded by the host.
  - I: N×N result array; on an accepted start, I is set to the identity (diagonal = 1<<FRAC, all others 0).
- States: IDLE → SEARCH → SWAP → DIV → NORM → ELIM → (next column k or FIN) → IDLE.
- SEARCH: scan r = k..N−1, one row per cycle; stop at the first r with A[r][k] ≠ 0 and set p = r. If none is found, go to FIN with singular = 1.
- SWAP: always 1 cycle. Exchange rows k and p in both A and I; when p = k this is a no-op.
- DIV: sequential restoring divider, exactly 2·W cycles.
  - R = sign(piv) · floor(2^(2·FRAC) / |piv|), where piv = A[k][k].
  - R saturates to [−2^(W−1), 2^(W−1)−1].
- NORM: N cycles; cycle j updates A[k][j] and I[k][j].
  - x ← sat((x·R) >>> FRAC).
  - The product is 2W bits wide; >>> is an arithmetic shift (floor).
- ELIM: for each row r ≠ k, in ascending order:
  - 1 cycle latches f = A[r][k];
  - then N cycles, where cycle j computes A[r][j] ← sat(A[r][j] − ((f·A[k][j]) >>> FRAC)), and the same update for I.
  - Row k is skipped and costs no cycles.
- FIN: 1 cycle. done = 1, busy = 0, then return to IDLE.
- On completion A holds ≈ identity and I holds the inverse. A is consumed, so the host must reload it before the next start.
- On a singular result the contents of I are undefined; A is partially reduced.
- wr_en and start are ignored while busy.
- If wr_en and start are asserted in the same idle cycle, the write lands first and is included in the computation.
- Reads are allowed at any time. While busy, data_out shows intermediate values of I.

## Timing
- Reset values: busy 0, done 0, singular 0, data_out 0, all A and I elements 0, state IDLE.
- Reset asserted mid-operation aborts immediately with the same values as above. No done pulse is produced.
- Let start be sampled at rising edge 0. Then busy = 1 from edge 0 to edge L−1.
- done is high for exactly one cycle, at edge L, where busy = 0.
- L = 1 + Σ_k [(p_k − k + 1) + 1 + 2W + N + (N−1)(N+1)].
- On the singular path, L ends at the failing SEARCH: its scan costs N − k cycles, followed by FIN.
- Read latency is 1 cycle: rd_addr at edge t gives data_out at edge t+1.
- A write is visible to the next accepted start. A read of A is not exposed.
- rd_addr ≥ N·N returns 0. wr_addr ≥ N·N is ignored.

## Test plan
- Identity (N=5, W=32, FRAC=16): load the diagonal with 0x00010000 and start.
  - done at L = 476.
  - I diagonal = 0x00010000, off-diagonal = 0, singular = 0.
- Diagonal (2,4,0.5,1,8) in Q16.16: read I diagonal = 0x8000, 0x4000, 0x20000, 0x10000, 0x2000.
- Pivot swap (N=2): A = [[0,1],[1,0]].
  - Inverse = A.
  - L = 1 + (2+1+64+2+3) + (1+1+64+2+3) = 144.
- Singular: column 2 all zero → done with singular = 1.
  - singular stays set through idle.
  - The next valid start clears it and produces a correct identity result.
- Busy protection: during busy, write 0x7FFF0000 to address 0 and pulse start.
  - The result is unchanged and no second done occurs.
- Reset mid-DIV: assert reset low for 1 cycle.
  - busy = 0, done never pulses, data_out = 0.
  - A reload plus start then gives the identity result at L = 476.
